// File: rtl/fir_pkg.sv
// Shared types and default widths for the FIR stream sink.
package fir_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through register FIFO. The head entry is always visible on
// o_dout; an empty FIFO presents zero so stale storage never leaks out.
module axis_sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is data only, so it is left out of reset; the level gates its visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/fir_axis_sink.sv
// Sink stage for the FIR output stream: buffers beats, counts them against the
// programmed length, regenerates tlast and reports framing status.
module fir_axis_sink
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_W,
  parameter int pDEPTH_LOG2 = 4,
  parameter int pCNT_WIDTH  = CNT_W
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pCNT_WIDTH-1:0]  cfg_data_length,
  input  logic                   start,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   err_early_last,
  output logic                   err_missing_last,
  output logic [pCNT_WIDTH-1:0]  sample_cnt,
  output logic [pDEPTH_LOG2:0]   fifo_level
);
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [pCNT_WIDTH-1:0]   r_len_q;
  logic [pCNT_WIDTH-1:0]   r_sample_cnt;
  logic                    r_done;
  logic                    r_err_early;
  logic                    r_err_missing;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_final;
  logic                    w_start_ok;
  logic                    w_len_zero;
  logic [pDATA_WIDTH:0]    w_fifo_dout;

  assign w_final    = (r_sample_cnt == r_len_q - 1'b1);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_len_zero = (cfg_data_length == '0);
  // Ready comes from registered occupancy only, so a same-cycle pop cannot reopen it.
  assign s_tready   = (r_state == ST_RUN) && !w_full;
  assign w_accept   = s_tvalid && s_tready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = w_len_zero ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (w_accept && w_final) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_empty) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state       <= ST_IDLE;
      r_len_q       <= '0;
      r_sample_cnt  <= '0;
      r_done        <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_len_q       <= cfg_data_length;
        r_sample_cnt  <= '0;
        r_done        <= w_len_zero;
        r_err_early   <= 1'b0;
        r_err_missing <= 1'b0;
      end else begin
        if (w_accept) begin
          r_sample_cnt <= r_sample_cnt + 1'b1;
          if (s_tlast && !w_final) r_err_early   <= 1'b1;
          if (!s_tlast && w_final) r_err_missing <= 1'b1;
        end
        if ((r_state == ST_DRAIN) && w_empty) r_done <= 1'b1;
      end
    end
  end

  // Payload carries the regenerated last flag alongside the untouched data word.
  axis_sync_fifo #(
    .WIDTH      (pDATA_WIDTH + 1),
    .DEPTH_LOG2 (pDEPTH_LOG2)
  ) u_fifo (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .i_push  (w_accept),
    .i_pop   (m_tvalid && m_tready),
    .i_din   ({w_final, s_tdata}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign m_tvalid          = !w_empty;
  assign {m_tlast, m_tdata} = w_fifo_dout;
  assign busy              = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done              = r_done;
  assign err_early_last    = r_err_early;
  assign err_missing_last  = r_err_missing;
  assign sample_cnt        = r_sample_cnt;
endmodule

// File: tb/tb_fir_axis_sink.sv
// Bench for fir_axis_sink: scenario table plus hand-written corner sequences,
// checked every cycle against a queue-based reference model.
module tb_fir_axis_sink;
  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic [31:0] cfg_data_length;
  logic        start;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic        done;
  logic        err_early_last;
  logic        err_missing_last;
  logic [31:0] sample_cnt;
  logic [4:0]  fifo_level;

  fir_axis_sink #(.pDATA_WIDTH(32), .pDEPTH_LOG2(4), .pCNT_WIDTH(32)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .cfg_data_length(cfg_data_length),
    .start(start), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .done(done), .err_early_last(err_early_last),
    .err_missing_last(err_missing_last), .sample_cnt(sample_cnt), .fifo_level(fifo_level)
  );

  always #5 axis_clk = ~axis_clk;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  int          total = 0;
  int          bad   = 0;
  int          ph;
  int unsigned m_len, m_cnt;
  bit          m_done, m_early, m_missing;
  logic [32:0] q[$];
  int          pops;
  int          src_idx;
  bit          last_acc;

  typedef struct {
    int len; int last_at; int spct; int mpct; int pulse_cyc;
    bit e_done; bit e_early; bit e_missing; int e_beats;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    ph = P_IDLE; m_len = 0; m_cnt = 0;
    m_done = 0; m_early = 0; m_missing = 0;
    q.delete();
  endtask

  // Check outputs for the current cycle, advance the model across the edge, then step.
  task automatic cycle();
    logic exp_rdy, acc, pop, fin, drain_done;
    exp_rdy = (ph == P_RUN) && (q.size() < 16);
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, q.size() != 0);
    chk("m_tdata", m_tdata, (q.size() != 0) ? q[0][31:0] : 32'd0);
    chk("m_tlast", m_tlast, (q.size() != 0) ? q[0][32] : 1'b0);
    chk("busy", busy, (ph == P_RUN) || (ph == P_DRAIN));
    chk("done", done, m_done);
    chk("err_early", err_early_last, m_early);
    chk("err_missing", err_missing_last, m_missing);
    chk("sample_cnt", sample_cnt, m_cnt);
    chk("fifo_level", fifo_level, q.size());
    acc = s_tvalid && exp_rdy;
    pop = (q.size() != 0) && m_tready;
    drain_done = (ph == P_DRAIN) && (q.size() == 0);
    last_acc = acc && !axis_rst;
    if (axis_rst) mdl_reset();
    else begin
      if (pop) begin q.delete(0); pops++; end
      if (start && (ph == P_IDLE || ph == P_DONE)) begin
        m_len = cfg_data_length; m_cnt = 0;
        m_early = 0; m_missing = 0;
        m_done = (m_len == 0);
        ph = (m_len == 0) ? P_DONE : P_RUN;
      end else if (acc) begin
        fin = (m_cnt == m_len - 1);
        q.push_back({fin, s_tdata});
        m_cnt++;
        if (s_tlast && !fin) m_early = 1;
        if (!s_tlast && fin) m_missing = 1;
        if (fin) ph = P_DRAIN;
      end else if (drain_done) begin
        ph = P_DONE; m_done = 1;
      end
    end
    @(posedge axis_clk); #1;
  endtask

  // Source keeps a beat stable until it is accepted, then maybe offers the next.
  task automatic src_next(input int last_at, input int pct);
    if (last_acc) src_idx++;
    if (last_acc || !s_tvalid) begin
      if ($urandom_range(99) < pct) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tlast  = (src_idx == last_at);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input int len, input int last_at, input int spct,
                           input int mpct, input int pulse_cyc);
    bit fin_ok;
    fin_ok = 0;
    pops = 0; src_idx = 0; last_acc = 0;
    s_tvalid = 0; s_tlast = 0;
    cfg_data_length = len; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (ph == P_DONE && q.size() == 0) begin fin_ok = 1; break; end
      if (c == pulse_cyc) begin start = 1'b1; cfg_data_length = 3; end
      else start = 1'b0;
      m_tready = ($urandom_range(99) < mpct);
      src_next(last_at, spct);
      cycle();
    end
    start = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!fin_ok) chk("frame_timeout", 1, 0);
    cycle();
  endtask

  initial begin
    vecs[0] = '{600, 599, 100, 100, -1, 1'b1, 1'b0, 1'b0, 600};
    vecs[1] = '{8,   3,   100, 100, -1, 1'b1, 1'b1, 1'b1, 8};
    vecs[2] = '{0,   -1,  100, 100, -1, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{5,   -1,  70,  60,  -1, 1'b1, 1'b0, 1'b1, 5};
    vecs[4] = '{20,  19,  50,  50,  -1, 1'b1, 1'b0, 1'b0, 20};
    vecs[5] = '{10,  9,   100, 40,  4,  1'b1, 1'b0, 1'b0, 10};

    axis_rst = 1; cfg_data_length = 0; start = 0;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0;
    @(posedge axis_clk); #1;
    mdl_reset();
    cycle();
    axis_rst = 0;
    cycle();

    foreach (vecs[i]) begin
      run_frame(vecs[i].len, vecs[i].last_at, vecs[i].spct, vecs[i].mpct, vecs[i].pulse_cyc);
      chk("vec_done", done, vecs[i].e_done);
      chk("vec_early", err_early_last, vecs[i].e_early);
      chk("vec_missing", err_missing_last, vecs[i].e_missing);
      chk("vec_beats", pops, vecs[i].e_beats);
      chk("vec_cnt", sample_cnt, vecs[i].len);
      chk("vec_level", fifo_level, 0);
    end

    // Backpressure: sink stalls until the FIFO fills, then drains everything.
    pops = 0; src_idx = 0; last_acc = 0; s_tvalid = 0;
    cfg_data_length = 20; start = 1; m_tready = 0;
    cycle();
    start = 0;
    for (int c = 0; c < 30; c++) begin src_next(19, 100); cycle(); end
    chk("bp_level_full", fifo_level, 16);
    chk("bp_ready_low", s_tready, 0);
    chk("bp_not_done", done, 0);
    m_tready = 1;
    for (int c = 0; c < 200 && !(ph == P_DONE && q.size() == 0); c++) begin
      src_next(19, 100); cycle();
    end
    s_tvalid = 0;
    cycle();
    chk("bp_beats", pops, 20);
    chk("bp_done", done, 1);

    // Reset mid-frame with buffered beats, then a clean short frame.
    pops = 0; src_idx = 0; last_acc = 0; s_tvalid = 0;
    cfg_data_length = 50; start = 1; m_tready = 0;
    cycle();
    start = 0;
    for (int c = 0; c < 100 && m_cnt < 10; c++) begin src_next(49, 100); cycle(); end
    s_tvalid = 0; m_tready = 1;
    for (int c = 0; c < 5; c++) cycle();
    chk("rst_pre_level", fifo_level, 5);
    axis_rst = 1; m_tready = 0;
    cycle();
    axis_rst = 0;
    chk("rst_level", fifo_level, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sample_cnt, 0);
    run_frame(4, 3, 100, 100, -1);
    chk("post_rst_beats", pops, 4);
    chk("post_rst_done", done, 1);
    chk("post_rst_errs", {err_early_last, err_missing_last}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_axis_sink.md
Name: fir_axis_sink

Overview:
- Downstream stage of the FIR core. Consumes the FIR's AXI-Stream output (sm_tvalid/sm_tdata/sm_tlast/sm_tready) through its slave port.
- Buffers results in a small first-word-fall-through FIFO and re-presents them on an AXI-Stream master port toward DMA or host.
- Counts samples against the programmed data length, regenerates tlast on the last expected sample, and reports sticky framing errors and done status for the control block.

Parameters:
pDATA_WIDTH, 32, stream data width
pDEPTH_LOG2, 4, log2 of FIFO depth (depth 16)
pCNT_WIDTH, 32, sample counter and length width

Ports:
axis_clk  in  1  clock, all logic on rising edge
axis_rst  in  1  reset, synchronous, active-high
cfg_data_length  in  pCNT_WIDTH  expected sample count, sampled on start
start  in  1  one-cycle pulse, arms a new frame
s_tvalid  in  1  upstream (FIR sm_tvalid)
s_tdata  in  pDATA_WIDTH  upstream data
s_tlast  in  1  upstream last flag (checked only)
s_tready  out  1  backpressure to FIR
m_tvalid  out  1  downstream valid
m_tdata  out  pDATA_WIDTH  downstream data
m_tlast  out  1  regenerated last flag
m_tready  in  1  downstream ready
busy  out  1  high in RUN or DRAIN
done  out  1  sticky; set on DRAIN->DONE; cleared by accepted start
err_early_last  out  1  sticky; s_tlast seen before the final expected beat
err_missing_last  out  1  sticky; final expected beat arrived without s_tlast
sample_cnt  out  pCNT_WIDTH  beats accepted this frame
fifo_level  out  pDEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset values (axis_rst=1 at an edge): state IDLE; FIFO emptied; every output listed above = 0, including s_tready, m_tvalid, m_tdata, m_tlast, busy, done, both errors, sample_cnt, fifo_level. Reset mid-frame discards FIFO contents and aborts the frame without setting done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - latch len_q = cfg_data_length;
  - clear sample_cnt, done, err_early_last, err_missing_last;
  - go to RUN, or straight to DONE with done=1 if len_q==0.
- start in RUN/DRAIN is ignored.
- RUN:
  - s_tready = !full (combinational from occupancy). A beat is accepted when s_tvalid&&s_tready.
  - Each accepted beat is pushed with stored last = (sample_cnt==len_q-1); sample_cnt increments.
  - Accepted s_tlast with sample_cnt<len_q-1 sets err_early_last; the frame continues.
  - Accepted final beat without s_tlast sets err_missing_last.
  - After the final beat is accepted, go to DRAIN.
- DRAIN: s_tready=0; when the FIFO is empty (after the last pop), go to DONE and set done=1 in the same edge.
- IDLE/DONE: s_tready=0. Upstream beats are not accepted; they stall at the source.
- FIFO:
  - FWFT, register storage, depth 2^pDEPTH_LOG2.
  - m_tvalid = !empty; m_tdata/m_tlast = head entry.
  - Latency: a beat accepted at edge N is visible on m_* after edge N (one cycle), with no combinational s->m path.
  - Pop on m_tvalid&&m_tready.
  - Simultaneous push and pop: level unchanged, both succeed, including at level 1.
  - Full: push is blocked via s_tready=0; a pop in the same cycle does not re-open ready until the next cycle.
  - Pointers wrap modulo depth; fifo_level distinguishes full from empty.
- m_tvalid, once high, holds with stable m_tdata/m_tlast until popped (AXI-Stream rule).
- sample_cnt does not exceed len_q; no beats are accepted beyond len_q.
- Data is passed through unmodified (no arithmetic on tdata).

Decomposition:
- Package fir_pkg: state enum (IDLE, RUN, DRAIN, DONE) and default width constants DATA_W=32, CNT_W=32.
- Sub-module axis_sync_fifo (FWFT, parameterised width/depth, push/pop/full/empty/level) instantiated once for the {tlast,tdata} payload. Control FSM and counter stay in fir_axis_sink.

Test Plan:
- Normal frame: len=600, 600 beats with s_tlast on beat 599, m_tready=1 -> 600 beats out in order, m_tlast only on beat 599, done=1, no errors, sample_cnt=600, fifo_level=0.
- Backpressure: len=20, m_tready=0 for 30 cycles -> fifo_level reaches 16, s_tready=0 while full. Release -> all 20 values out in order, done=1 only after the last pop.
- Early last: len=8, s_tlast asserted on beat 3 -> err_early_last=1, err_missing_last=1, 8 beats out, m_tlast only on beat 7, done=1.
- Zero length: cfg_data_length=0, start -> DONE next edge, done=1, s_tready stays 0, no output.
- Reset mid-frame: len=50, reset after 10 beats with 5 still buffered -> all outputs 0 next cycle, FIFO empty, done=0. New start with len=4 -> clean 4-beat frame.
- Start ignored while busy: start pulse during RUN with cfg_data_length=3 and len_q=10 -> frame still completes at 10 beats.
